// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-port memory arbiter:
// FSM state encoding, port indices, timeout read fill and small helpers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } arb_state_t;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 22;
  localparam int DATA_W    = 8;

  localparam logic [1:0] PORT_VIDEO  = 2'd0;
  localparam logic [1:0] PORT_CPU    = 2'd1;
  localparam logic [1:0] PORT_LOADER = 2'd2;
  localparam logic [1:0] GNT_NONE    = 2'd3;

  // Returned on rdata when a transaction is abandoned after a timeout.
  localparam logic [DATA_W-1:0] TIMEOUT_FILL = 8'hFF;

  // Fixed priority among the requesters: video > cpu > loader.
  function automatic logic [1:0] pick_port(input logic [NUM_PORTS-1:0] r);
    if (r[0]) return PORT_VIDEO;
    if (r[1]) return PORT_CPU;
    if (r[2]) return PORT_LOADER;
    return GNT_NONE;
  endfunction

  // One-hot ack vector for a grant index; GNT_NONE (refresh) yields no ack.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] p);
    case (p)
      PORT_VIDEO:  return 3'b001;
      PORT_CPU:    return 3'b010;
      PORT_LOADER: return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_refresh_timer.sv
// Refresh bookkeeping: a free-running tick counter that fires every
// REFRESH_INTERVAL cycles and a saturating 3-bit count of refreshes owed.
// Only instantiated when MEM_ARB_REFRESH_EN is defined.
module mem_refresh_timer
  import mem_arb_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       refresh_issue,
  output logic [2:0] pending
);

  localparam int TICK_W = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_INTERVAL - 1);

  logic [TICK_W-1:0] tick_cnt_reg;
  logic [2:0]        pending_reg;
  logic              tick;

  assign tick    = (tick_cnt_reg == TICK_LAST);
  assign pending = pending_reg;

  // Interval counter wraps on the tick cycle.
  always_ff @(posedge clk) begin
    if (!resetn) tick_cnt_reg <= '0;
    else if (tick) tick_cnt_reg <= '0;
    else tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  // Owed-refresh count: +1 per tick (saturating), -1 per issued refresh.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_reg <= 3'd0;
    end else begin
      case ({tick, refresh_issue})
        2'b10:   if (pending_reg != 3'd7) pending_reg <= pending_reg + 3'd1;
        2'b01:   if (pending_reg != 3'd0) pending_reg <= pending_reg - 3'd1;
        default: pending_reg <= pending_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-port (video, cpu, loader) arbiter in front of a single-byte memory
// controller with a busy handshake. Optional refresh scheduling is compiled
// in when MEM_ARB_REFRESH_EN is defined; otherwise mem_refresh is tied low.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 200,
  parameter int REFRESH_URGENT   = 2,
  parameter int TIMEOUT          = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [65:0] addr,
  input  logic [23:0] wdata,
  output logic [2:0]  ack,
  output logic [7:0]  rdata,
  output logic [1:0]  gnt,
  output logic        arb_busy,
  output logic        err,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_refresh,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  input  logic        mem_busy
);

  // Wide enough to hold TIMEOUT without wrapping.
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  arb_state_t state_reg, state_next;

  logic [CNT_W-1:0]     wait_cnt_reg;
  logic                 we_reg;
  logic                 is_ref_reg;
  logic [1:0]           gnt_reg;
  logic [NUM_PORTS-1:0] ack_reg;
  logic [DATA_W-1:0]    rdata_reg;
  logic                 err_reg;
  logic [ADDR_W-1:0]    addr_reg;
  logic [DATA_W-1:0]    din_reg;

  logic grant_now, done_now, abort_now, timed_out;
  logic win_valid, win_ref;
  logic [1:0] win_port;
  logic ref_urgent, ref_any;

  // Per-port views of the packed buses; slot 3 is the "no port" entry used
  // by refresh grants so that indexing by a 2-bit grant is always in range.
  logic [ADDR_W-1:0] port_addr  [4];
  logic [DATA_W-1:0] port_wdata [4];
  logic [3:0]        port_we;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign port_addr[gi]  = addr[ADDR_W*gi +: ADDR_W];
    assign port_wdata[gi] = wdata[DATA_W*gi +: DATA_W];
  end
  assign port_addr[3]  = '0;
  assign port_wdata[3] = '0;
  assign port_we       = {1'b0, we};

`ifdef MEM_ARB_REFRESH_EN
  logic [2:0] pending;
  logic       refresh_issue;

  assign refresh_issue = (state_reg == ST_ISSUE) && is_ref_reg;

  mem_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk          (clk),
    .resetn       (resetn),
    .refresh_issue(refresh_issue),
    .pending      (pending)
  );

  assign ref_urgent = (int'(pending) >= REFRESH_URGENT);
  assign ref_any    = (pending != 3'd0);
`else
  assign ref_urgent = 1'b0;
  assign ref_any    = 1'b0;
`endif

  assign timed_out = (wait_cnt_reg == CNT_W'(TIMEOUT));

  // Pick the next winner: urgent refresh, then ports by priority, then any owed refresh.
  always_comb begin
    win_valid = 1'b1;
    win_ref   = 1'b0;
    win_port  = GNT_NONE;
    if (ref_urgent) begin
      win_ref = 1'b1;
    end else if (|req) begin
      win_port = pick_port(req);
    end else if (ref_any) begin
      win_ref = 1'b1;
    end else begin
      win_valid = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= ST_IDLE;
    else state_reg <= state_next;
  end

  // Next-state and command pulses. No grant in the ack cycle: the acked
  // requester still holds req there and must not be served twice.
  always_comb begin
    state_next  = state_reg;
    grant_now   = 1'b0;
    done_now    = 1'b0;
    abort_now   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_refresh = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!mem_busy && (ack_reg == '0) && win_valid) begin
          grant_now  = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_read  = !is_ref_reg && !we_reg;
        mem_write = !is_ref_reg && we_reg;
`ifdef MEM_ARB_REFRESH_EN
        mem_refresh = is_ref_reg;
`endif
        state_next = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (timed_out) begin
          abort_now  = 1'b1;
          state_next = ST_IDLE;
        end else if (mem_busy) begin
          state_next = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!mem_busy) begin
          done_now   = 1'b1;
          state_next = ST_IDLE;
        end else if (timed_out) begin
          abort_now  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Transaction datapath: latch the winner, count wait cycles, complete or abort.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt_reg <= '0;
      we_reg       <= 1'b0;
      is_ref_reg   <= 1'b0;
      gnt_reg      <= GNT_NONE;
      ack_reg      <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      addr_reg     <= '0;
      din_reg      <= '0;
    end else begin
      ack_reg <= '0;
      if (grant_now) begin
        addr_reg     <= port_addr[win_port];
        din_reg      <= port_wdata[win_port];
        we_reg       <= win_ref ? 1'b0 : port_we[win_port];
        is_ref_reg   <= win_ref;
        gnt_reg      <= win_port;
        wait_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT_HI || state_reg == ST_WAIT_LO) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
      if (done_now) begin
        ack_reg <= port_onehot(gnt_reg);
        if (!we_reg && !is_ref_reg) rdata_reg <= mem_dout;
        gnt_reg <= GNT_NONE;
      end
      if (abort_now) begin
        err_reg <= 1'b1;
        ack_reg <= port_onehot(gnt_reg);
        if (!is_ref_reg) rdata_reg <= TIMEOUT_FILL;
        gnt_reg <= GNT_NONE;
      end
    end
  end

  assign ack      = ack_reg;
  assign rdata    = rdata_reg;
  assign gnt      = gnt_reg;
  assign err      = err_reg;
  assign arb_busy = (state_reg != ST_IDLE);
  assign mem_addr = addr_reg;
  assign mem_din  = din_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small busy-handshake memory
// model. Refresh-specific checks are active when MEM_ARB_REFRESH_EN is defined.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  we = '0;
  logic [65:0] addr = '0;
  logic [23:0] wdata = '0;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic [1:0]  gnt;
  logic        arb_busy, err, mem_read, mem_write, mem_refresh;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = '0;
  logic        mem_busy;
  logic        force_busy = 1'b0;
  logic        model_busy = 1'b0;

  assign mem_busy = force_busy | model_busy;

  int checks = 0;
  int passed = 0;

  int model_lat = 4;
  int model_cnt = 0;
  int n_read = 0, n_write = 0, n_ref = 0, bad_pulse = 0;
  logic [21:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [7:0]  last_wr_din = '0;
  logic        prev_cmd = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .REFRESH_INTERVAL(16),
    .REFRESH_URGENT  (2),
    .TIMEOUT         (255)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .ack        (ack),
    .rdata      (rdata),
    .gnt        (gnt),
    .arb_busy   (arb_busy),
    .err        (err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_refresh(mem_refresh),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_busy   (mem_busy)
  );

  function automatic logic [7:0] mdata(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Memory model: any command raises busy for model_lat cycles.
  always @(negedge clk) begin
    if (model_cnt > 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) model_busy = 1'b0;
    end
    if ((int'(mem_read) + int'(mem_write) + int'(mem_refresh)) > 1) bad_pulse++;
    if (mem_read || mem_write || mem_refresh) begin
      if (prev_cmd) bad_pulse++;
      model_busy = 1'b1;
      model_cnt  = model_lat;
      if (mem_read) begin
        n_read++;
        last_rd_addr = mem_addr;
        mem_dout     = mdata(mem_addr);
      end
      if (mem_write) begin
        n_write++;
        last_wr_addr = mem_addr;
        last_wr_din  = mem_din;
      end
      if (mem_refresh) n_ref++;
    end
    prev_cmd = mem_read || mem_write || mem_refresh;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic w, input logic [21:0] a, input logic [7:0] d);
    we[p]            = w;
    addr[22*p +: 22] = a;
    wdata[8*p +: 8]  = d;
  endtask

  task automatic wait_ack(input int p, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ack[p]) begin
        ok = 1'b1;
        $display("txn: port %0d ack rdata=%02h err=%0b", p, rdata, err);
        return;
      end
    end
  endtask

  task automatic wait_model_idle();
    for (int i = 0; i < 600 && mem_busy; i++) step();
  endtask

  task automatic do_reset();
    wait_model_idle();
    req    = '0;
    resetn = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   ok;
    int   got;
    int   order [3];
    int   idx;
    int   w0;
    logic [7:0] exp_rd [3];
    exp_rd[0] = 8'h2C;
    exp_rd[1] = 8'h1C;
    exp_rd[2] = 8'h0C;

    // Reset state
    resetn = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(arb_busy), 0);
    check("rst_gnt", 32'(gnt), 3);
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cmd", 32'({mem_read, mem_write, mem_refresh}), 0);
    check("rst_rdata", 32'(rdata), 0);

    // Memory busy after reset: nothing issued until it clears
    force_busy = 1'b1;
    resetn     = 1'b1;
    set_port(1, 1'b0, 22'h012345, 8'h00);
    req[1] = 1'b1;
    repeat (100) step();
    check("t1_nocmd", 32'(n_read + n_write + n_ref), 0);
    check("t1_idle", 32'(arb_busy), 0);
    force_busy = 1'b0;
    wait_ack(1, 150, ok);
    req[1] = 1'b0;
    check("t1_ack", 32'(ok), 1);
    check("t1_addr", 32'(last_rd_addr), 32'h012345);
    check("t1_rdata", 32'(rdata), 32'h5A);

    // All three ports read at once: served video, cpu, loader
    set_port(0, 1'b0, 22'h000010, 8'h00);
    set_port(1, 1'b0, 22'h000020, 8'h00);
    set_port(2, 1'b0, 22'h000030, 8'h00);
    req = 3'b111;
    got = 0;
    for (int i = 0; i < 300 && got < 3; i++) begin
      step();
      if (ack != 3'b000) begin
        check("t2_onehot", 32'($countones(ack)), 1);
        idx = ack[0] ? 0 : (ack[1] ? 1 : 2);
        order[got] = idx;
        $display("txn: port %0d ack rdata=%02h", idx, rdata);
        check("t2_rdata", 32'(rdata), 32'(exp_rd[idx]));
        req[idx] = 1'b0;
        got++;
      end
    end
    check("t2_count", 32'(got), 3);
    check("t2_order0", 32'(order[0]), 0);
    check("t2_order1", 32'(order[1]), 1);
    check("t2_order2", 32'(order[2]), 2);

    // CPU write: one write pulse, data latched, rdata untouched
    w0 = n_write;
    set_port(1, 1'b1, 22'h000100, 8'hA5);
    req[1] = 1'b1;
    wait_ack(1, 100, ok);
    req[1] = 1'b0;
    check("t3_ack", 32'(ok), 1);
    check("t3_wcount", 32'(n_write - w0), 1);
    check("t3_waddr", 32'(last_wr_addr), 32'h000100);
    check("t3_wdin", 32'(last_wr_din), 32'hA5);
    check("t3_mem_din", 32'(mem_din), 32'hA5);
    check("t3_busy_low", 32'(mem_busy), 0);
    check("t3_rdata", 32'(rdata), 32'h0C);
    we[1] = 1'b0;

`ifdef MEM_ARB_REFRESH_EN
    // Continuous video reads: refresh only once two are owed
    begin
      int first_ref, r0, v0;
      do_reset();
      set_port(0, 1'b0, 22'h000040, 8'h00);
      req[0]    = 1'b1;
      first_ref = -1;
      r0        = n_ref;
      v0        = n_read;
      for (int i = 1; i <= 200; i++) begin
        step();
        if (first_ref < 0 && n_ref != r0) first_ref = i;
      end
      req[0] = 1'b0;
      $display("txn: refresh window first=%0d refreshes=%0d reads=%0d", first_ref, n_ref - r0, n_read - v0);
      check("t4_first_ref_lo", 32'(first_ref >= 30), 1);
      check("t4_first_ref_hi", 32'(first_ref <= 45), 1);
      check("t4_ref_count", 32'((n_ref - r0) >= 8), 1);
      check("t4_video_count", 32'((n_read - v0) >= 15), 1);
    end
`endif

    // Memory stuck busy: timeout, err, 0xFF read
    do_reset();
    check("t5_err_clear", 32'(err), 0);
    model_lat = 400;
    set_port(1, 1'b0, 22'h000200, 8'h00);
    req[1] = 1'b1;
    wait_ack(1, 400, ok);
    req[1] = 1'b0;
    check("t5_ack", 32'(ok), 1);
    check("t5_err", 32'(err), 1);
    check("t5_rdata", 32'(rdata), 32'hFF);
    check("t5_idle", 32'(arb_busy), 0);
    model_lat = 4;
    wait_model_idle();
    set_port(2, 1'b0, 22'h000030, 8'h00);
    req[2] = 1'b1;
    wait_ack(2, 200, ok);
    req[2] = 1'b0;
    check("t5_next_ack", 32'(ok), 1);
    check("t5_next_rdata", 32'(rdata), 32'h0C);
    check("t5_err_sticky", 32'(err), 1);

    // Reset while waiting on the memory: abort with no ack
    do_reset();
    model_lat = 10;
    set_port(1, 1'b0, 22'h000400, 8'h00);
    req[1] = 1'b1;
    for (int i = 0; i < 50 && !model_busy; i++) step();
    repeat (3) step();
    check("t6_inflight", 32'(arb_busy), 1);
    resetn = 1'b0;
    req    = '0;
    step();
    check("t6_busy", 32'(arb_busy), 0);
    check("t6_ack", 32'(ack), 0);
    check("t6_gnt", 32'(gnt), 3);
    check("t6_err", 32'(err), 0);
    resetn = 1'b1;
    got = 0;
    repeat (20) begin
      step();
      if (ack != 3'b000) got++;
    end
    check("t6_noack", 32'(got), 0);
    $display("txn: reset abort acks after release=%0d", got);
    model_lat = 4;

    check("cmd_pulses", 32'(bad_pulse), 0);
`ifndef MEM_ARB_REFRESH_EN
    check("no_refresh", 32'(n_ref), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter REFRESH_INTERVAL, 200, clk cycles between refresh ticks.
REQ-002 Parameter REFRESH_URGENT, 2, pending-refresh count at which refresh takes top priority.
REQ-003 Parameter TIMEOUT, 255, max clk cycles in a wait state before abort.
REQ-004 Port clk  in  1  clock; all logic on its rising edge.
REQ-005 Port resetn  in  1  reset, synchronous, active-low.
REQ-006 Port req  in  3  per-port request level; index 0 video, 1 cpu, 2 loader.
REQ-007 Port we  in  3  per-port write (1) / read (0).
REQ-008 Port addr  in  66  per-port 22-bit byte address, port n at [22n+21:22n].
REQ-009 Port wdata  in  24  per-port write byte, port n at [8n+7:8n].
REQ-010 Port ack  out  3  one-cycle completion pulse per port.
REQ-011 Port rdata  out  8  read byte; valid in the cycle ack is high.
REQ-012 Port gnt  out  2  index of the port being served; 3 = refresh/none.
REQ-013 Port arb_busy  out  1  high whenever state is not IDLE.
REQ-014 Port err  out  1  sticky timeout flag.
REQ-015 Port mem_read, mem_write, mem_refresh  out  1 each  one-cycle command pulses to the memory controller.
REQ-016 Port mem_addr  out  22; mem_din  out  8; mem_dout  in  8; mem_busy  in  1.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT_HI, WAIT_LO.
REQ-018 IDLE SHALL grant only when mem_busy=0; while mem_busy=1 (including post-reset init/test) no command is issued.
REQ-019 Grant priority SHALL be: refresh if pending>=REFRESH_URGENT; else video > cpu > loader; else refresh if pending>0.
REQ-020 On grant, mem_addr/mem_din SHALL latch the winner's addr/wdata and hold stable until return to IDLE.
REQ-021 ISSUE SHALL assert exactly one of mem_read/mem_write/mem_refresh for exactly one cycle.
REQ-022 WAIT_HI SHALL advance to WAIT_LO when mem_busy=1; WAIT_LO SHALL, when mem_busy=0, latch mem_dout into rdata (reads only), pulse ack for the granted port, and return to IDLE.
REQ-023 Writes SHALL leave rdata unchanged; refresh SHALL produce no ack.
REQ-024 Requesters hold req/we/addr/wdata until ack; req still high the cycle after ack is a new transaction.
REQ-025 If WAIT_HI+WAIT_LO exceed TIMEOUT cycles: err<=1, ack pulsed with rdata=8'hFF (refresh: no ack), return to IDLE.
REQ-026 Refresh pending counter (3 bits) SHALL increment per tick, saturate at 7, decrement on refresh ISSUE; simultaneous tick and issue leaves it unchanged.
REQ-027 A req deasserted before grant SHALL be ignored; a req deasserted after grant SHALL not abort the transaction.

Reset
REQ-028 resetn=0 SHALL, at the next edge, force IDLE, all outputs 0 (gnt=3), pending=0, tick counter=0, err=0, aborting any in-flight transaction without ack.

Configuration
REQ-029 With MEM_ARB_REFRESH_EN defined, the refresh tick counter, pending counter and refresh grant path SHALL exist as above.
REQ-030 Without MEM_ARB_REFRESH_EN, mem_refresh SHALL be constant 0, pending logic absent, priority video > cpu > loader only.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state enum, port index constants (PORT_VIDEO=0, PORT_CPU=1, PORT_LOADER=2, GNT_NONE=3) and the 8'hFF timeout fill value.
REQ-032 Sub-module mem_refresh_timer SHALL contain the tick and pending counters, instantiated only under MEM_ARB_REFRESH_EN.

Verification
REQ-033 mem_busy=1 for 100 cycles after reset, req[1]=1 read addr 22'h012345 -> no command until mem_busy=0, then mem_read pulse with mem_addr=22'h012345.
REQ-034 req=3'b111 all reads, model busy 4 cycles -> acks in order port0, port1, port2, each rdata equal to model data.
REQ-035 cpu write addr 22'h000100 data 8'hA5 -> single mem_write pulse, mem_din=8'hA5, ack[1] after mem_busy falls, rdata unchanged.
REQ-036 REFRESH_INTERVAL=16, req[0] held continuously -> after pending reaches 2, next IDLE issues mem_refresh before the next video read.
REQ-037 mem_busy stuck high 300 cycles, TIMEOUT=255 -> err=1, ack for granted port with rdata=8'hFF, return to IDLE.
REQ-038 resetn=0 during WAIT_LO -> next cycle arb_busy=0, ack=0, gnt=3, no ack for the aborted port.
